// File: rtl/fifo_pkg.sv
// ============================================================================
// fifo_pkg : shared defaults, pointer-wrap helper and error-flag type
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

    localparam int DEFAULT_WIDTH     = 8;
    localparam int DEFAULT_DEPTH     = 16;
    localparam int DEFAULT_AF_MARGIN = 2;
    localparam int DEFAULT_AE_MARGIN = 2;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_mem.sv
// ============================================================================
// fifo_mem : DEPTH x WIDTH storage, one write port, combinational read port
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEFAULT_DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read returns the pre-edge contents, giving read-before-write.
    assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// sync_fifo : single-clock FIFO with count, threshold and sticky error flags
// Option    : define SYNC_FIFO_FWFT_EN for first-word-fall-through output
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

module sync_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int AF_MARGIN = DEFAULT_AF_MARGIN,
    parameter int AE_MARGIN = DEFAULT_AE_MARGIN
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       pop,
    output logic [WIDTH-1:0]           data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(DEPTH - AF_MARGIN);
    localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_MARGIN);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr_inc;
    logic [PTR_W-1:0] wr_ptr_inc;
    logic [PTR_W-1:0] raddr;
    logic [WIDTH-1:0] mem_rdata;
    logic             pop_ok;
    logic             push_ok;
    logic             wr_en;
    fifo_err_t        err;

    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop);
    assign wr_en   = push_ok && !clear;

    assign rd_ptr_inc = PTR_W'(ptr_inc(32'(rd_ptr), 32'(DEPTH)));
    assign wr_ptr_inc = PTR_W'(ptr_inc(32'(wr_ptr), 32'(DEPTH)));

`ifdef SYNC_FIFO_FWFT_EN
    // Look one entry ahead so the next head is ready on the popping edge.
    assign raddr = rd_ptr_inc;
`else
    assign raddr = rd_ptr;
`endif

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (raddr),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
            err      <= '0;
        end else if (clear) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
            err      <= '0;
        end else begin
            if (pop_ok) begin
                rd_ptr <= rd_ptr_inc;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr_inc;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase
            err.overflow  <= err.overflow  || (push && full && !pop);
            err.underflow <= err.underflow || (pop && empty);
`ifdef SYNC_FIFO_FWFT_EN
            // A single remaining entry is replaced by the word pushed alongside, if any.
            if (pop_ok) begin
                if (count == ONE_CNT) begin
                    data_out <= push_ok ? data_in : '0;
                end else begin
                    data_out <= mem_rdata;
                end
            end else if (push_ok && empty) begin
                data_out <= data_in;
            end
`else
            if (pop_ok) begin
                data_out <= mem_rdata;
            end
`endif
        end
    end

    assign full         = (count == FULL_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);
    assign overflow     = err.overflow;
    assign underflow    = err.underflow;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo.sv
// ============================================================================
// tb_sync_fifo : randomized and directed bench for sync_fifo, DEPTH 16 and 5
// Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       clear = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] data_in = 8'h00;

    logic [7:0] do16, do5;
    logic       full16, empty16, af16, ae16, ov16, un16;
    logic       full5, empty5, af5, ae5, ov5, un5;
    logic [4:0] cnt16;
    logic [2:0] cnt5;

    int checks = 0;
    int failures = 0;

    // Reference state: queues hold contents, plus sticky flags and expected output.
    logic [7:0] q16[$];
    logic [7:0] q5[$];
    bit         m_ov16, m_un16, m_ov5, m_un5;
    logic [7:0] m_do16, m_do5;

    always #5 clk = ~clk;

    sync_fifo #(.WIDTH(8), .DEPTH(16), .AF_MARGIN(2), .AE_MARGIN(2)) u_dut16 (
        .clk(clk), .rstn(rstn), .clear(clear), .push(push), .data_in(data_in),
        .pop(pop), .data_out(do16), .full(full16), .empty(empty16),
        .almost_full(af16), .almost_empty(ae16), .count(cnt16),
        .overflow(ov16), .underflow(un16)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(5), .AF_MARGIN(1), .AE_MARGIN(2)) u_dut5 (
        .clk(clk), .rstn(rstn), .clear(clear), .push(push), .data_in(data_in),
        .pop(pop), .data_out(do5), .full(full5), .empty(empty5),
        .almost_full(af5), .almost_empty(ae5), .count(cnt5),
        .overflow(ov5), .underflow(un5)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q16.delete();
        q5.delete();
        m_ov16 = 0; m_un16 = 0; m_ov5 = 0; m_un5 = 0;
        m_do16 = 8'h00; m_do5 = 8'h00;
    endtask

    task automatic model_edge();
        bit p_ok, w_ok;
        if (clear) begin
            model_reset();
            return;
        end
        // DEPTH 16 instance
        p_ok = pop && (q16.size() != 0);
        w_ok = push && ((q16.size() != 16) || pop);
        if (push && q16.size() == 16 && !pop) m_ov16 = 1;
        if (pop && q16.size() == 0) m_un16 = 1;
        if (p_ok) m_do16 = q16.pop_front();
        if (w_ok) q16.push_back(data_in);
        // DEPTH 5 instance
        p_ok = pop && (q5.size() != 0);
        w_ok = push && ((q5.size() != 5) || pop);
        if (push && q5.size() == 5 && !pop) m_ov5 = 1;
        if (pop && q5.size() == 0) m_un5 = 1;
        if (p_ok) m_do5 = q5.pop_front();
        if (w_ok) q5.push_back(data_in);
`ifdef SYNC_FIFO_FWFT_EN
        m_do16 = (q16.size() != 0) ? q16[0] : 8'h00;
        m_do5  = (q5.size()  != 0) ? q5[0]  : 8'h00;
`endif
    endtask

    task automatic check_all();
        check_val("cnt16",   32'(cnt16),   32'(q16.size()));
        check_val("full16",  32'(full16),  32'(q16.size() == 16));
        check_val("empty16", 32'(empty16), 32'(q16.size() == 0));
        check_val("af16",    32'(af16),    32'(q16.size() >= 14));
        check_val("ae16",    32'(ae16),    32'(q16.size() <= 2));
        check_val("ov16",    32'(ov16),    32'(m_ov16));
        check_val("un16",    32'(un16),    32'(m_un16));
        check_val("do16",    32'(do16),    32'(m_do16));
        check_val("cnt5",    32'(cnt5),    32'(q5.size()));
        check_val("full5",   32'(full5),   32'(q5.size() == 5));
        check_val("empty5",  32'(empty5),  32'(q5.size() == 0));
        check_val("af5",     32'(af5),     32'(q5.size() >= 4));
        check_val("ae5",     32'(ae5),     32'(q5.size() <= 2));
        check_val("ov5",     32'(ov5),     32'(m_ov5));
        check_val("un5",     32'(un5),     32'(m_un5));
        check_val("do5",     32'(do5),     32'(m_do5));
    endtask

    task automatic cyc(input logic c, input logic pu, input logic po, input logic [7:0] d);
        clear = c; push = pu; pop = po; data_in = d;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        clear = 1'b0; push = 1'b0; pop = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rstn = 1'b1;

        // Fill with 0x01..0x10, then a refused push
        for (int i = 1; i <= 16; i++) cyc(1'b0, 1'b1, 1'b0, 8'(i));
        check_val("fill_count", 32'(cnt16), 32'd16);
        cyc(1'b0, 1'b1, 1'b0, 8'hAA);
        check_val("ovf_set", 32'(ov16), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 8'h11);
        // Full with push+pop, then drain and pop one past empty
        cyc(1'b0, 1'b1, 1'b1, 8'h55);
        check_val("full_pp_count", 32'(cnt16), 32'd16);
        for (int i = 0; i < 17; i++) cyc(1'b0, 1'b0, 1'b1, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);

        // Empty with push+pop
        cyc(1'b0, 1'b1, 1'b1, 8'h33);
        check_val("empty_pp_unf", 32'(un16), 32'd1);
        check_val("empty_pp_cnt", 32'(cnt16), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);

        // Interleaved traffic at count 3 to wrap the DEPTH 5 pointers
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 1'b1, 8'(8'h60 + i));
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 8'h00);

        // Clear together with a push while half full
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 8'(8'h80 + i));
        cyc(1'b0, 1'b1, 1'b0, 8'hAA);
        cyc(1'b1, 1'b1, 1'b1, 8'hBB);
        check_val("clear_cnt", 32'(cnt16), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 8'h7E);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);

        // Asynchronous reset pulse mid-stream
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, (i % 3) == 0, 8'(8'hC0 + i));
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        check_all();
        #2;
        rstn = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 8'h12);

        // Randomized traffic with occasional clears
        for (int i = 0; i < 600; i++) begin
            int phase;
            logic pu, po, cl;
            phase = (i / 100) % 3;
            pu = ($urandom_range(0, 9) < (phase == 0 ? 8 : (phase == 1 ? 3 : 5)));
            po = ($urandom_range(0, 9) < (phase == 0 ? 3 : (phase == 1 ? 8 : 5)));
            cl = ($urandom_range(0, 59) == 0);
            cyc(cl, pu, po, 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sync_fifo.md
# sync_fifo

Parametrised single-clock FIFO; the general-purpose buffering block used between producers and consumers in the same clock domain. Any data width, any depth ≥ 2 (power of two not required), occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush. A compile-time option selects first-word-fall-through output.

## Interface
- WIDTH, 8, data width in bits (≥ 1)
- DEPTH, 16, number of entries (≥ 2)
- AF_MARGIN, 2, almost_full when count ≥ DEPTH − AF_MARGIN (1 ≤ AF_MARGIN < DEPTH)
- AE_MARGIN, 2, almost_empty when count ≤ AE_MARGIN (0 ≤ AE_MARGIN < DEPTH)
- clk  in  1  clock, all logic on rising edge
- rstn  in  1  asynchronous, active-low reset
- clear  in  1  synchronous flush
- push  in  1  write request
- data_in  in  WIDTH  write data
- pop  in  1  read request
- data_out  out  WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  threshold flag
- almost_empty  out  1  threshold flag
- count  out  $clog2(DEPTH+1)  occupancy
- overflow  out  1  sticky: push refused
- underflow  out  1  sticky: pop refused

## Operation
- Reset (rstn low, async): pointers 0, count 0, data_out 0, empty 1, almost_empty 1, full 0, almost_full 0, overflow 0, underflow 0. Storage contents not reset.
- pop_ok = pop && !empty. push_ok = push && (!full || pop). Full + push + pop: both accepted, count unchanged.
- Empty + push + pop: push accepted, pop refused, underflow set.
- overflow set on push && full && !pop; underflow set on pop && empty. Both hold until clear or reset.
- Pointers wrap DEPTH−1 → 0 explicitly (no reliance on binary rollover).
- count: +1 on push_ok only, −1 on pop_ok only, unchanged on both or neither. All flags decoded from registered count, so they are registered outputs.
- clear has priority over push/pop: pointers and count to 0, overflow/underflow to 0, data_out to 0; push/pop in that cycle ignored, no error flagged.
- Storage read-before-write: full with simultaneous push/pop at same index returns old entry.

## Timing
- Default (macro absent): data_out loads head entry on the edge where pop_ok; valid the cycle after pop; holds otherwise.
- Push-to-empty deassert: 1 cycle. Push to poppable: next cycle.
- Flags and count change on the same edge as the accepted operation.
- Reset asserted mid-operation: all outputs to reset values immediately (async); first push accepted on the first edge after rstn rises.

## Configuration
- SYNC_FIFO_FWFT_EN defined: first-word-fall-through. data_out continuously shows the head entry when !empty (registered, updated on the same edge as the push into an empty FIFO or the pop); pop acknowledges/consumes it. When empty, data_out holds 0. Push-to-data_out valid latency 1 cycle.
- Undefined: registered-read behaviour above.

## Structure
- Package fifo_pkg: default parameter constants, function for wrapping pointer increment (ptr, DEPTH), typedef fifo_err_t {overflow, underflow}.
- Sub-module fifo_mem: DEPTH×WIDTH array, one write port, one read port with combinational read address; sync_fifo holds pointers, count, flags, output register.

## Test plan
- Reset then fill DEPTH=16 with 0x01..0x10 → count 16, full 1, almost_full set at count 14; drain → 0x01..0x10 in order, empty 1 after 16th pop.
- Fill to full, push 0xAA alone → refused, overflow 1, count 16; pop → 0x01, overflow stays 1 until clear.
- Full, push 0x55 + pop same cycle → pop returns head, count stays 16; after draining, 0x55 is last.
- Empty, push 0x33 + pop same cycle → underflow 1, count 1; next pop returns 0x33.
- DEPTH=5, 12 push/pop pairs interleaved at count 3 → pointers wrap, data order preserved, almost_empty tracks count ≤ 2.
- Half full, assert clear with push → count 0, empty 1, errors 0, data_out 0; repeat with rstn pulsed mid-stream → same; with SYNC_FIFO_FWFT_EN, push 0x7E into empty → data_out 0x7E next cycle without pop.
